// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The slave modport is the adder's view and the master modport is the producer/consumer view.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;
  logic             zero;
  logic             neg;

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ov, zero, neg
  );

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ov, zero, neg
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor: an input rank followed by LAT
// compute stages, each resolving GRP_PER_STG 4-bit CLA groups; stall-able valid/ready on both sides.
module cla_addsub_pipe #(
  parameter int WIDTH       = 32,
  parameter int GRP_PER_STG = 2
) (
  input logic              clk,
  input logic              reset_n,
  cla_addsub_pipe_if.slave bus
);

  localparam int SW  = 4 * GRP_PER_STG;
  localparam int LAT = WIDTH / SW;

  if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_width_check
    $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of 4*GRP_PER_STG");
  end

  typedef struct packed {
    logic [3:0] sum;
    logic       g;
    logic       p;
    logic       c3;
  } cla4_t;

  typedef struct packed {
    logic [SW-1:0] sum;
    logic          cout;
    logic          cmsb;
  } stg_t;

  // 4-bit lookahead group; c3 is the carry into the group's top bit (needed for ov)
  function automatic cla4_t cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    cla4_t      r;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    r.sum = p ^ c;
    r.g   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p   = &p;
    r.c3  = c[3];
    return r;
  endfunction

  // Second-level lookahead: every group carry is a sum of products of group G/P and cin
  function automatic logic [GRP_PER_STG:0] grp_carries(
    input logic [GRP_PER_STG-1:0] gg,
    input logic [GRP_PER_STG-1:0] pp,
    input logic                   cin
  );
    logic [GRP_PER_STG:0] gc;
    logic                 term;
    logic                 prod;
    gc[0] = cin;
    for (int j = 0; j < GRP_PER_STG; j++) begin
      term = gg[j];
      prod = pp[j];
      for (int i = j - 1; i >= 0; i--) begin
        term = term | (prod & gg[i]);
        prod = prod & pp[i];
      end
      gc[j+1] = term | (prod & cin);
    end
    return gc;
  endfunction

  // One pipeline stage worth of sum bits from an SW-bit operand slice
  function automatic stg_t stage_eval(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic cin);
    logic [GRP_PER_STG-1:0] gg;
    logic [GRP_PER_STG-1:0] pp;
    logic [GRP_PER_STG:0]   gc;
    cla4_t                  r;
    stg_t                   o;
    for (int j = 0; j < GRP_PER_STG; j++) begin
      r     = cla4(x[4*j +: 4], y[4*j +: 4], 1'b0);
      gg[j] = r.g;
      pp[j] = r.p;
    end
    gc    = grp_carries(gg, pp, cin);
    o.sum = {SW{1'b0}};
    r     = cla4(x[3:0], y[3:0], gc[0]);
    for (int j = 0; j < GRP_PER_STG; j++) begin
      r               = cla4(x[4*j +: 4], y[4*j +: 4], gc[j]);
      o.sum[4*j +: 4] = r.sum;
    end
    o.cmsb = r.c3;
    o.cout = gc[GRP_PER_STG];
    return o;
  endfunction

  logic             en_s;
  logic [LAT:0]     v_q;
  logic [LAT:0]     v_d;
  logic [WIDTH-1:0] a_q [LAT];
  logic [WIDTH-1:0] a_d [LAT];
  logic [WIDTH-1:0] b_q [LAT];
  logic [WIDTH-1:0] b_d [LAT];
  logic [WIDTH-1:0] s_q [LAT+1];
  logic [WIDTH-1:0] s_d [LAT+1];
  logic [LAT:0]     c_q;
  logic [LAT:0]     c_d;
  stg_t             st_s [LAT];
  logic             ov_q;
  logic             ov_d;
  logic             zero_q;
  logic             zero_d;
  logic             neg_q;
  logic             neg_d;

  // Next-state for every rank; rank 0 captures effective operands, rank k+1 gets stage k's slice
  always_comb begin
    en_s   = !v_q[LAT] || bus.out_ready;
    v_d    = {v_q[LAT-1:0], bus.in_valid};
    a_d[0] = bus.a;
    b_d[0] = bus.sub ? ~bus.b : bus.b;
    c_d[0] = bus.ci ^ bus.sub;
    s_d[0] = {WIDTH{1'b0}};
    for (int k = 1; k < LAT; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
    for (int k = 0; k < LAT; k++) begin
      st_s[k]                 = stage_eval(a_q[k][k*SW +: SW], b_q[k][k*SW +: SW], c_q[k]);
      s_d[k+1]                = s_q[k];
      s_d[k+1][k*SW +: SW]    = st_s[k].sum;
      c_d[k+1]                = st_s[k].cout;
    end
    ov_d   = c_d[LAT] ^ st_s[LAT-1].cmsb;
    zero_d = (s_d[LAT] == {WIDTH{1'b0}});
    neg_d  = s_d[LAT][WIDTH-1];
  end

  // Pipeline ranks: all advance together on en, all hold otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q    <= {(LAT+1){1'b0}};
      c_q    <= {(LAT+1){1'b0}};
      ov_q   <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        a_q[k] <= {WIDTH{1'b0}};
        b_q[k] <= {WIDTH{1'b0}};
      end
      for (int k = 0; k <= LAT; k++) begin
        s_q[k] <= {WIDTH{1'b0}};
      end
    end else if (en_s) begin
      v_q    <= v_d;
      c_q    <= c_d;
      ov_q   <= ov_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      for (int k = 0; k < LAT; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
      for (int k = 0; k <= LAT; k++) begin
        s_q[k] <= s_d[k];
      end
    end
  end

  assign bus.in_ready  = en_s;
  assign bus.out_valid = v_q[LAT];
  assign bus.s         = s_q[LAT];
  assign bus.co        = c_q[LAT];
  assign bus.ov        = ov_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe: a driver pushes expected results on acceptance,
// an independent monitor pops and compares on every output transfer.
module tb_cla_addsub_pipe;

  localparam int LAT = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        zero;
    logic        neg;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    res_t        r;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  res_t exp_q [$];
  vec_t dir_v [11];

  cla_addsub_pipe_if #(.WIDTH(32)) bus ();

  cla_addsub_pipe #(.WIDTH(32), .GRP_PER_STG(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub);
    logic [31:0] be;
    logic [32:0] t;
    res_t        r;
    be     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + {32'd0, ci ^ sub};
    r.s    = t[31:0];
    r.co   = t[32];
    r.ov   = (a[31] == be[31]) && (t[31] != a[31]);
    r.zero = (t[31:0] == 32'd0);
    r.neg  = t[31];
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub,
                              input logic [31:0] s, input logic co, input logic ov, input logic z, input logic n);
    vec_t v;
    v.a      = a;
    v.b      = b;
    v.ci     = ci;
    v.sub    = sub;
    v.r.s    = s;
    v.r.co   = co;
    v.r.ov   = ov;
    v.r.zero = z;
    v.r.neg  = n;
    return v;
  endfunction

  task automatic idle(input int rdy_pct);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
    bus.a         = $urandom;
    bus.b         = $urandom;
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub,
                      input res_t e, input int rdy_pct);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = a;
      bus.b         = b;
      bus.ci        = ci;
      bus.sub       = sub;
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (bus.in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      guard++;
      if (!done && guard > 1000) begin
        chk("send_timeout", 64'd1, 64'd0);
        done = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      idle(100);
      g++;
    end
    idle(100);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare every retired result, and require s/flags to hold across stalled cycles
  logic  held_v;
  res_t  held_r;
  res_t  got_r;
  res_t  e_r;
  initial held_v = 1'b0;
  always begin
    @(negedge clk);
    #2;
    got_r = {bus.s, bus.co, bus.ov, bus.zero, bus.neg};
    if (!reset_n) begin
      held_v = 1'b0;
    end else begin
      if (bus.out_valid && !bus.out_ready) begin
        if (held_v) chk("stall_hold", 64'(got_r), 64'(held_r));
        held_v = 1'b1;
        held_r = got_r;
      end else begin
        held_v = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(got_r), 64'd0 - 64'd1);
        end else begin
          e_r = exp_q.pop_front();
          chk("result", 64'(got_r), 64'(e_r));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    dir_v[0]  = mk(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
    dir_v[1]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    dir_v[2]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    dir_v[3]  = mk(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    dir_v[4]  = mk(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
    dir_v[5]  = mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    dir_v[6]  = mk(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    dir_v[7]  = mk(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    dir_v[8]  = mk(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    dir_v[9]  = mk(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    dir_v[10] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.ci        = 1'b0;
    bus.sub       = 1'b0;
    #3;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_result", 64'({bus.s, bus.co, bus.ov, bus.zero, bus.neg}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // latency: a lone op must surface exactly LAT edges after acceptance
    send(dir_v[0].a, dir_v[0].b, dir_v[0].ci, dir_v[0].sub, dir_v[0].r, 100);
    for (int i = 0; i <= LAT; i++) begin
      idle(100);
      chk("latency_out_valid", 64'(bus.out_valid), 64'(i == LAT));
    end
    drain();

    for (int i = 1; i < 11; i++) begin
      send(dir_v[i].a, dir_v[i].b, dir_v[i].ci, dir_v[i].sub, dir_v[i].r, 100);
    end
    drain();

    // back-pressure: 8 ops streamed, consumer stalls on cycles 6..9
    begin
      int cnt;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        bus.out_ready = !(c >= 6 && c <= 9);
        if (cnt < 8) begin
          bus.in_valid = 1'b1;
          bus.a        = 32'(cnt) * 32'h1111_1111;
          bus.b        = 32'hF000_0000 + 32'(cnt);
          bus.ci       = cnt[0];
          bus.sub      = cnt[1];
        end else begin
          bus.in_valid = 1'b0;
        end
        #1;
        if (c >= 6 && c <= 9) chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
          cnt++;
        end
      end
      chk("bp_accepted", 64'(cnt), 64'd8);
    end
    drain();

    // reset mid-flight with three ops in the pipe, the oldest stalled at the output
    begin
      int g;
      for (int i = 0; i < 3; i++) begin
        send(32'h1234_0000 + 32'(i), 32'h0000_1111, 1'b0, 1'b0, model(32'h1234_0000 + 32'(i), 32'h0000_1111, 1'b0, 1'b0), 0);
      end
      g = 0;
      do begin
        idle(0);
        g++;
      end while (!bus.out_valid && g < 20);
      chk("rst_pipe_filled", 64'(bus.out_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_async_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_async_s", 64'(bus.s), 64'd0);
      exp_q.delete();
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 10; i++) begin
        idle(100);
        chk("rst_no_stale", 64'(bus.out_valid), 64'd0);
      end
    end

    // random operands with bubbles and random consumer stalls
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic        rs;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) idle(75);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), 75);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
